// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   DEFAULT_N : default data/address width (memory depth is 2**DEFAULT_N)
//   state_e   : arbiter controller states
package mem_arb_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin winner selection (purely combinational).
//   req0, req1  : pending requests
//   last_served : 0 = requester 0 was served last, 1 = requester 1
//   pick0/pick1 : one-hot winner, both low when nobody requests
module mem_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic pick0,
    output logic pick1
);

    // On a tie the requester that was not served last wins.
    assign pick0 = req0 & (~req1 | last_served);
    assign pick1 = req1 & (~req0 | ~last_served);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters onto one shared single-port memory and clears the
// whole memory after every reset.
//   clk, rst                   : clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*      : per-requester request, held until its gnt
//   gnt*                       : one-cycle pulse when the request is sampled
//   done*, rdata*              : completion pulse and read data (held afterwards)
//   busy                       : high during the post-reset clear sweep
//   mem_we/mem_addr/mem_wdata  : memory command, mem_rdata : memory read data
//
// state  | meaning
// INIT   | clear sweep, one word per cycle, requests ignored
// IDLE   | waiting for a request; grants the round-robin winner
// ACCESS | latched command presented to the memory for one cycle
// RESP   | memory read back, winner's done pulses, last_served updated
module memory_arbiter #(
    parameter int unsigned N = mem_arb_pkg::DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic         busy,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         last_q, last_d;
    logic         win_q, win_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata0_q, rdata0_d;
    logic [N-1:0] rdata1_q, rdata1_d;
    logic         pick0, pick1;

    mem_arb_rr u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_q),
        .pick0       (pick0),
        .pick1       (pick1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;

        case (state_q)
            INIT: begin
                // Counter parks on the last address; it restarts only via reset.
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            IDLE: begin
                if (pick0 | pick1) begin
                    gnt0    = pick0;
                    gnt1    = pick1;
                    win_d   = pick1;
                    we_d    = pick1 ? we1    : we0;
                    addr_d  = pick1 ? addr1  : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                done0  = ~win_q;
                done1  = win_q;
                last_d = win_q;
                if (win_q) begin
                    rdata1_d = mem_rdata;
                end else begin
                    rdata0_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // INIT would otherwise write during reset; gating with rst keeps the
    // memory quiet while reset is held.
    assign mem_we    = rst & ((state_q == INIT) | ((state_q == ACCESS) & we_q));
    assign mem_addr  = (state_q == INIT) ? cnt_q : addr_q;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign busy      = (state_q == INIT);

    // The word being captured in RESP is forwarded so rdata is valid in the
    // same cycle as done; the register holds it from then on.
    assign rdata0 = done0 ? mem_rdata : rdata0_q;
    assign rdata1 = done1 ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] rdata0, rdata1;
    logic       busy, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rd_exp [2];

    memory_arbiter #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Shared memory: synchronous write, asynchronous read, pre-filled with
    // 0xEE so that a missing clear sweep shows up in read data.
    logic [7:0] mem [256];
    bit seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
            seeded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_gnt0"},  int'(gnt0), 0);
        check({name, "_gnt1"},  int'(gnt1), 0);
        check({name, "_done0"}, int'(done0), 0);
        check({name, "_done1"}, int'(done1), 0);
        check({name, "_rdata0"}, int'(rdata0), 0);
        check({name, "_rdata1"}, int'(rdata1), 0);
        check({name, "_mem_we"}, int'(mem_we), 0);
        check({name, "_mem_addr"}, int'(mem_addr), 0);
        check({name, "_mem_wdata"}, int'(mem_wdata), 0);
        check({name, "_busy"}, int'(busy), 1);
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals(name);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
    endtask

    // Starts at the negedge where rst was released; returns at negedge+1 of
    // the first IDLE cycle.
    task automatic check_sweep(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (i == 0)   check({name, "_sweep_first_addr"}, int'(mem_addr), 0);
            if (i == 255) check({name, "_sweep_last_addr"}, int'(mem_addr), 255);
            if (busy !== 1'b1 || mem_we !== 1'b1 || int'(mem_addr) != i ||
                mem_wdata !== 8'h00 || gnt0 !== 1'b0 || gnt1 !== 1'b0)
                bad++;
            @(negedge clk);
        end
        check({name, "_sweep_errs"}, bad, 0);
        #1;
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_mem_we_after"}, int'(mem_we), 0);
    endtask

    task automatic do_txn(input bit who, input bit we, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] exp, input string name);
        bit got = 1'b0;
        if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
        #1;
        for (int k = 0; k < 8; k++) begin
            if ((who ? gnt1 : gnt0) === 1'b1) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        check({name, "_gnt"}, int'(got), 1);
        check({name, "_other_gnt"}, int'(who ? gnt0 : gnt1), 0);
        @(posedge clk); #1;
        if (who) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        check({name, "_done_early"}, int'(who ? done1 : done0), 0);
        @(negedge clk);
        check({name, "_done"}, int'(who ? done1 : done0), 1);
        check({name, "_other_done"}, int'(who ? done0 : done1), 0);
        check({name, "_rdata"}, int'(who ? rdata1 : rdata0), int'(exp));
        check({name, "_other_rdata"}, int'(who ? rdata0 : rdata1), int'(rd_exp[!who]));
        rd_exp[who] = exp;
        @(negedge clk);
    endtask

    task automatic run_random(input int ncyc);
        int next_free = 0;
        int last = 1;
        int done_at = -1;
        int done_who = 0;
        int exp_g, exp_d;
        logic [7:0] done_val = 8'h00;
        logic [7:0] shadow [256];
        logic [7:0] erd [2];
        bit p_req [2];
        bit p_we [2];
        logic [7:0] p_addr [2];
        logic [7:0] p_wd [2];
        bit obs0, obs1;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        for (int r = 0; r < 2; r++) begin
            erd[r] = 8'h00; p_req[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = 8'h00; p_wd[r] = 8'h00;
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            exp_g = -1;
            if (cyc >= next_free) begin
                if (p_req[0] && p_req[1]) exp_g = 1 - last;
                else if (p_req[0])        exp_g = 0;
                else if (p_req[1])        exp_g = 1;
            end
            exp_d = (cyc == done_at) ? done_who : -1;
            if (exp_d >= 0) erd[exp_d] = done_val;
            check("rnd_gnt0", int'(gnt0), int'(exp_g == 0));
            check("rnd_gnt1", int'(gnt1), int'(exp_g == 1));
            check("rnd_done0", int'(done0), int'(exp_d == 0));
            check("rnd_done1", int'(done1), int'(exp_d == 1));
            check("rnd_rdata0", int'(rdata0), int'(erd[0]));
            check("rnd_rdata1", int'(rdata1), int'(erd[1]));
            obs0 = gnt0;
            obs1 = gnt1;
            if (exp_g >= 0) begin
                if (p_we[exp_g]) shadow[p_addr[exp_g]] = p_wd[exp_g];
                done_val  = shadow[p_addr[exp_g]];
                done_at   = cyc + 2;
                done_who  = exp_g;
                last      = exp_g;
                next_free = cyc + 3;
            end
            @(posedge clk); #1;
            if (obs0) p_req[0] = 1'b0;
            if (obs1) p_req[1] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (!p_req[r] && $urandom_range(0, 2) == 0) begin
                    p_req[r]  = 1'b1;
                    p_we[r]   = 1'($urandom_range(0, 1));
                    p_addr[r] = 8'($urandom_range(0, 15));
                    p_wd[r]   = 8'($urandom);
                end
            end
            req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
            req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
            @(negedge clk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    typedef struct {
        bit         who;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;

        vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'hA5};
        vecs[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 8'h00, 8'h3C, 8'h3C};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h3C};
        vecs[5]  = '{1'b1, 1'b1, 8'hFF, 8'h81, 8'h81};
        vecs[6]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h81};
        vecs[7]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[8]  = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h5A};
        vecs[9]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[10] = '{1'b0, 1'b0, 8'h7F, 8'h00, 8'h00};

        // Request raised during the sweep is granted only in the first IDLE cycle.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h55;
        apply_reset("rst0");
        check_sweep("init");
        check("init_req_gnt0_first_idle", int'(gnt0), 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("init_req_done0", int'(done0), 1);
        check("init_req_rdata0_cleared", int'(rdata0), 0);
        rd_exp[0] = 8'h00;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            do_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                   $sformatf("vec%0d", i));

        // Reset in the ACCESS cycle of a write to 0x20.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h77;
        #1;
        check("midrst_gnt0", int'(gnt0), 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        check("midrst_access_we", int'(mem_we), 1);
        check("midrst_access_addr", int'(mem_addr), 'h20);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        check("midrst_no_done0_a", int'(done0), 0);
        @(negedge clk);
        check("midrst_no_done0_b", int'(done0), 0);
        rd_exp[0] = 8'h00;
        rd_exp[1] = 8'h00;
        rst = 1'b1;
        check_sweep("midrst");

        // Both requesters reading continuously: strict alternation from requester 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        #1;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("tie_c%0d_gnt0", c), int'(gnt0), int'(c % 6 == 0));
            check($sformatf("tie_c%0d_gnt1", c), int'(gnt1), int'(c % 6 == 3));
            check($sformatf("tie_c%0d_done0", c), int'(done0), int'(c % 6 == 2));
            check($sformatf("tie_c%0d_done1", c), int'(done1), int'(c % 6 == 5));
            @(posedge clk); #1;
            if (c == 11) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk); #1;
        end

        do_txn(1'b0, 1'b1, 8'h01, 8'h99, 8'h99, "seed_rd0");

        // Requester 1 alone, read of 0xFF held: grant every third cycle.
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
        #1;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("solo_c%0d_gnt1", c), int'(gnt1), int'(c % 3 == 0));
            check($sformatf("solo_c%0d_gnt0", c), int'(gnt0), 0);
            check($sformatf("solo_c%0d_done1", c), int'(done1), int'(c % 3 == 2));
            if (c % 3 == 2) check($sformatf("solo_c%0d_rdata1", c), int'(rdata1), 0);
            check($sformatf("solo_c%0d_rdata0", c), int'(rdata0), 'h99);
            @(posedge clk); #1;
            if (c == 8) req1 = 1'b0;
            @(negedge clk); #1;
        end

        // Randomized traffic against the transaction-level model.
        apply_reset("rst_rand");
        check_sweep("rand");
        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, giving the data and address width; the memory holds 2^N words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: access request from requester 0 and requester 1.
REQ-005 SHALL have ports we0 and we1, input, 1 bit each: 1 selects write, 0 selects read, per requester.
REQ-006 SHALL have ports addr0, addr1, wdata0 and wdata1, input, N bits each: request address and write data.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle pulse in the cycle the request fields are sampled.
REQ-008 SHALL have ports done0 and done1, output, 1 bit each: one-cycle completion pulse.
REQ-009 SHALL have ports rdata0 and rdata1, output, N bits each: registered read data, valid when the matching done pulses.
REQ-010 SHALL have port busy, output, 1 bit: high while the post-reset clear sweep runs.
REQ-011 SHALL have ports mem_we (output, 1 bit), mem_addr and mem_wdata (output, N bits each), and mem_rdata (input, N bits): the shared single-port memory interface.

Function
REQ-012 SHALL implement FSM states INIT, IDLE, ACCESS and RESP.
REQ-013 INIT: SHALL drive mem_we=1, mem_wdata=0 and mem_addr=cnt; cnt counts 0 to 2^N-1, one word per cycle, with busy=1.
REQ-014 INIT SHALL go to IDLE after the cycle writing address 2^N-1, making busy=0; cnt SHALL NOT wrap into a second sweep.
REQ-015 INIT SHALL ignore all requests: no gnt is issued.
REQ-016 IDLE: if any req is high, SHALL pick a winner, pulse its gnt, latch its we, addr and wdata, and go to ACCESS; otherwise SHALL stay in IDLE with mem_we=0.
REQ-017 Arbitration SHALL be round-robin: a single requester wins; if both request, the one not served last wins; last_served resets to 1, so requester 0 wins the first tie.
REQ-018 ACCESS: SHALL drive mem_addr=latched addr, mem_wdata=latched wdata and mem_we=latched we for exactly one cycle, then go to RESP.
REQ-019 RESP: SHALL hold mem_addr with mem_we=0, capture mem_rdata into the winner's rdata, pulse the winner's done, update last_served, and go to IDLE.
REQ-020 A write transaction SHALL also return the read-back word in rdata.
REQ-021 Latency SHALL be gnt at cycle T, memory access at T+1, and done with rdata valid at T+2; next gnt no earlier than T+3.
REQ-022 Requesters SHALL hold req and fields stable until gnt; a req still high in the IDLE cycle after done counts as a new request.
REQ-023 rdata of the non-served requester SHALL hold its previous value.
REQ-024 gnt0 and gnt1 SHALL never be high together, and neither shall done0 and done1.

Reset
REQ-025 rst=0 SHALL immediately force state=INIT, cnt=0, last_served=1, and all outputs to reset values, from any state including mid-transaction.
REQ-026 Output reset values SHALL be: gnt0=gnt1=0, done0=done1=0, rdata0=rdata1=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=1.
REQ-027 A transaction interrupted by reset SHALL be dropped with no done pulse, and the sweep SHALL restart at address 0.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (INIT, IDLE, ACCESS, RESP) and the default width constant N=8.
REQ-029 The round-robin winner selection SHALL be the single sub-module mem_arb_rr: inputs req0, req1 and last_served; outputs pick0 and pick1, both combinational.

Verification
REQ-030 Deassert rst, N=8 -> busy=1 for 256 cycles with mem_we=1 and mem_addr going 0..255, then busy=0 and a readback of any address returns 0x00.
REQ-031 req0 write addr=0x10 wdata=0xA5, then req0 read addr=0x10 -> done0 two cycles after each gnt0, and rdata0=0xA5.
REQ-032 req0 and req1 reads held high together after reset -> grants in order gnt0, gnt1, gnt0, ..., spaced 3 cycles apart, never overlapping.
REQ-033 req1 held high alone with a read of addr=0xFF -> gnt1 every 3 cycles, rdata1=0x00, and rdata0 unchanged.
REQ-034 rst=0 during ACCESS of a write to 0x20 -> all outputs reset at once, no done pulse, and the sweep restarts at mem_addr=0.
REQ-035 req0 raised during INIT -> no gnt0 until the first IDLE cycle after busy falls.
